add_seq: RTL and testbench

Multi-cycle, parametrised ripple adder/subtractor for the CPU datapath. It is the successor to the single-bit full adder cell. It adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks through a registered carry. A start/busy/done handshake lets the control unit trade latency for area. Flags (carry, signed overflow, zero) are produced alongside the result for the status register.

---
 rtl/add_seq.sv | 140 ++++++++++++++
 tb/tb_add_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/add_seq.sv
// Multi-cycle ripple adder/subtractor: adds CHUNK bits per clock with a registered carry.
// Define ADD_SEQ_SUB_EN to enable subtract mode (sub input); otherwise the block only adds.
`timescale 1ns/1ps
module add_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [CHUNK-1:0] a_chunk, b_chunk, res_chunk;
   logic             chunk_cout;
   logic [WIDTH-1:0] b_in;
   logic             carry_in;
   logic             last;

`ifdef ADD_SEQ_SUB_EN
   assign b_in     = sub ? ~b : b;
   assign carry_in = sub ? 1'b1 : cin;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign b_in       = b;
   assign carry_in   = cin;
`endif

   assign last = (cnt_q == CW'(N - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
      a_chunk = '0;
      b_chunk = '0;

      // Constant-index mux keeps the chunk select clean for any N, including N = 1.
      for (int k = 0; k < int'(N); k++) begin
         if (cnt_q == CW'(k)) begin
            a_chunk = a_q[k*CHUNK +: CHUNK];
            b_chunk = b_q[k*CHUNK +: CHUNK];
         end
      end

      {chunk_cout, res_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRun;
               a_d     = a;
               b_d     = b_in;
               carry_d = carry_in;
               cnt_d   = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            for (int k = 0; k < int'(N); k++) begin
               if (cnt_q == CW'(k)) acc_d[k*CHUNK +: CHUNK] = res_chunk;
            end
            carry_d = chunk_cout;
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               state_d = StDone;
               cnt_d   = '0;
               sum_d   = acc_d;
               cout_d  = chunk_cout;
               // Same-sign operands giving an opposite-sign result == carry-in xor carry-out of MSB.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
               zero_d  = (acc_d == '0);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;
   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: 4-cycle (CHUNK=4) and 1-cycle (CHUNK=16) instances
// checked against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_add_seq;

`ifdef ADD_SEQ_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, start, start1, cin, sub;
   logic [15:0] a, b;
   logic [15:0] sum, sum1;
   logic        cout, ovf, zero, busy, done;
   logic        cout1, ovf1, zero1, busy1, done1;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   add_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .busy(busy), .done(done)
   );

   add_seq #(.WIDTH(16), .CHUNK(16)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin), .sub(sub),
      .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1), .busy(busy1), .done(done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns {ovf, cout, sum} from plain integer arithmetic.
   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mc, input logic ms);
      int unsigned u;
      int          s;
      logic [15:0] nb;
      if (SUB_EN && ms) begin
         nb = ~mb;
         u  = 32'(ma) + 32'(nb) + 32'd1;
         s  = int'($signed(ma)) - int'($signed(mb));
      end else begin
         u  = 32'(ma) + 32'(mb) + 32'(mc);
         s  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
      end
      return {(s > 32767 || s < -32768), u[16], u[15:0]};
   endfunction

   // One operation on the CHUNK=4 instance; checks latency, busy/done and result.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts);
      logic [17:0] m;
      logic [15:0] prev;
      m    = model(ta, tb_v, tc, ts);
      prev = sum;
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("sum_hold", sum, prev);
         a = 16'($urandom); b = 16'($urandom);
         @(posedge clk); #1;
      end
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("sum", sum, m[15:0]);
      chk("cout", cout, m[16]);
      chk("ovf", ovf, m[17]);
      chk("zero", zero, m[15:0] == 16'h0);
   endtask

   initial begin
      logic [17:0] m;
      rst = 1'b1; start = 1'b0; start1 = 1'b0; cin = 1'b0; sub = 1'b0; a = '0; b = '0;
      #12;
      chk("rst_sum", sum, 0);
      chk("rst_flags", {cout, ovf, zero, busy, done}, 0);
      chk("rst_sum1", sum1, 0);
      @(negedge clk); rst = 1'b0;

      run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
      chk("tp1_sum", sum, 16'h2201);
      chk("tp1_flags", {cout, ovf, zero}, 3'b000);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      chk("tp2_sum", sum, 16'h0000);
      chk("tp2_flags", {cout, ovf, zero}, 3'b101);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      chk("tp3_sum", sum, 16'h8000);
      chk("tp3_flags", {cout, ovf, zero}, 3'b010);
`ifdef ADD_SEQ_SUB_EN
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
      chk("tp4_sum", sum, 16'hFFFE);
      chk("tp4_flags", {cout, ovf, zero}, 3'b000);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
      chk("tp5_sum", sum, 16'h7FFF);
      chk("tp5_flags", {cout, ovf, zero}, 3'b110);
`endif

      for (int i = 0; i < 20; i++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

      // Idle gap, then start held high with operands toggling mid-run.
      @(posedge clk); #1;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      start = 1'b1;
      for (int op = 0; op < 4; op++) begin
         m = model(a, b, cin, sub);
         for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("hold_busy", busy, 1);
            chk("hold_done_lo", done, 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         end
         @(posedge clk); #1;
         chk("hold_done", done, 1);
         chk("hold_sum", sum, m[15:0]);
         chk("hold_flags", {ovf, cout, zero}, {m[17], m[16], m[15:0] == 16'h0});
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         if (op == 3) start = 1'b0;
      end

      // Asynchronous reset during the second RUN cycle.
      run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
      @(negedge clk);
      a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_sum", sum, 0);
      chk("arst_flags", {cout, ovf, zero, busy, done}, 0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("post_rst_idle", {busy, done}, 0);
      end
      run_op(16'h00FF, 16'h0F01, 1'b1, 1'b0);

      // Single-cycle instance.
      @(negedge clk);
      a = 16'h00FF; b = 16'h0001; cin = 1'b1; sub = 1'b0; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("c16_busy", busy1, 1);
      chk("c16_done_lo", done1, 0);
      @(posedge clk); #1;
      chk("c16_done", done1, 1);
      chk("c16_sum", sum1, 16'h0101);
      chk("c16_flags", {cout1, ovf1, zero1}, 3'b000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         m = model(a, b, cin, sub);
         start1 = 1'b1;
         @(posedge clk); #1;
         start1 = 1'b0;
         chk("c16r_busy", busy1, 1);
         @(posedge clk); #1;
         chk("c16r_done", done1, 1);
         chk("c16r_sum", sum1, m[15:0]);
         chk("c16r_flags", {ovf1, cout1, zero1}, {m[17], m[16], m[15:0] == 16'h0});
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
